rrf_commit_ctrl: RTL

Retirement sequencer between the ROB head and the retirement register file (RRF). It accepts one committing instruction per handshake and reads the displaced physical register from the RRF. It writes the new architectural-to-physical mapping and returns the displaced register to the free list. On a mispredict commit, it pulses a RAT restore so the speculative RAT reloads from the RRF state.

---
 rtl/module_types.sv | 13 +
 rtl/commit_perf_cnt.sv | 22 ++
 rtl/rrf_commit_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/module_types.sv
// Shared types for the retirement path: register widths and the commit sequencer states.
package module_types;

    localparam int PHYS_REG_ADDR = 6;
    localparam int ARCH_REGS     = 32;

    typedef enum logic [1:0] {
        IDLE,
        FREE,
        RESTORE
    } commit_state_t;

endpackage

// File: rtl/commit_perf_cnt.sv
// Commit and flush event counters for rrf_commit_ctrl; only built with RRF_COMMIT_PERF_EN.
module commit_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_evt,
    input  logic        flush_evt,
    output logic [31:0] commit_cnt,
    output logic [31:0] flush_cnt
);

    // Free-running counters that wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (commit_evt) commit_cnt <= commit_cnt + 32'd1;
            if (flush_evt)  flush_cnt  <= flush_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/rrf_commit_ctrl.sv
// Retirement sequencer: updates the RRF, frees displaced registers and restores the RAT on mispredicts.
// Optional event counters are enabled by defining RRF_COMMIT_PERF_EN.
module rrf_commit_ctrl #(
    parameter int PHYS_REG_ADDR = module_types::PHYS_REG_ADDR,
    parameter int ARCH_REGS     = module_types::ARCH_REGS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rob_valid,
    output logic                         rob_ready,
    input  logic                         rob_has_rd,
    input  logic [$clog2(ARCH_REGS)-1:0] rob_rd_arch,
    input  logic [PHYS_REG_ADDR-1:0]     rob_rd_phys,
    input  logic                         rob_mispredict,
    output logic [$clog2(ARCH_REGS)-1:0] rrf_r_addr,
    input  logic [PHYS_REG_ADDR-1:0]     rrf_r_data,
    output logic                         rrf_w_en,
    output logic [$clog2(ARCH_REGS)-1:0] rrf_w_addr,
    output logic [PHYS_REG_ADDR-1:0]     rrf_w_data,
    output logic                         fl_push_valid,
    input  logic                         fl_push_ready,
    output logic [PHYS_REG_ADDR-1:0]     fl_push_data,
    output logic                         rat_restore,
`ifdef RRF_COMMIT_PERF_EN
    output logic [31:0]                  commit_cnt,
    output logic [31:0]                  flush_cnt,
`endif
    output logic                         flush
);

    import module_types::*;

    commit_state_t              state;
    commit_state_t              next_state;
    logic [PHYS_REG_ADDR-1:0]   old_phys;
    logic                       flush_pending;
    logic                       fire;
    logic                       writes;

    // x0 is hardwired: its mapping is never replaced, so nothing is ever freed for it.
    assign writes     = rob_has_rd && (rob_rd_arch != '0);
    assign rrf_r_addr = rob_rd_arch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            old_phys      <= '0;
            flush_pending <= 1'b0;
        end else begin
            state <= next_state;
            if (fire && writes) begin
                old_phys      <= rrf_r_data;
                flush_pending <= rob_mispredict;
            end else if (state == RESTORE) begin
                flush_pending <= 1'b0;
            end
        end
    end

    // A FREE cycle whose push is accepted can also take the next entry, giving one commit per cycle.
    always_comb begin
        next_state    = state;
        rob_ready     = 1'b0;
        rrf_w_en      = 1'b0;
        rrf_w_addr    = '0;
        rrf_w_data    = '0;
        fl_push_valid = 1'b0;
        fl_push_data  = '0;
        rat_restore   = 1'b0;
        flush         = 1'b0;
        fire          = 1'b0;

        case (state)
            IDLE: begin
                rob_ready = 1'b1;
            end
            FREE: begin
                fl_push_valid = 1'b1;
                fl_push_data  = old_phys;
                rob_ready     = fl_push_ready && !flush_pending;
                if (fl_push_ready) begin
                    next_state = flush_pending ? RESTORE : IDLE;
                end
            end
            RESTORE: begin
                rat_restore = 1'b1;
                flush       = 1'b1;
                next_state  = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        fire = rob_valid && rob_ready;
        if (fire) begin
            if (writes) begin
                rrf_w_en   = 1'b1;
                rrf_w_addr = rob_rd_arch;
                rrf_w_data = rob_rd_phys;
                next_state = FREE;
            end else if (rob_mispredict) begin
                next_state = RESTORE;
            end else begin
                next_state = IDLE;
            end
        end
    end

`ifdef RRF_COMMIT_PERF_EN
    commit_perf_cnt u_perf (
        .clk        (clk),
        .rst        (rst),
        .commit_evt (fire),
        .flush_evt  (rat_restore),
        .commit_cnt (commit_cnt),
        .flush_cnt  (flush_cnt)
    );
`endif

endmodule
